// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length tap masks and the lockup-value helper shared by
// lfsr_core and lfsr_stats.
package lfsr_pkg;

   localparam int MIN_W = 3;
   localparam int MAX_W = 32;

   // Bit n-1 set for tap n; these sequences are maximal length for XNOR feedback.
   localparam logic [31:0] MAXLEN_TAPS [MIN_W:MAX_W] = '{
      32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030, // 3..6
      32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, // 7..10
      32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015, // 11..14
      32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400, // 15..18
      32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000, // 19..22
      32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, // 23..26
      32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029, // 27..30
      32'h4800_0000, 32'h8020_0003                                // 31..32
   };

   // All-ones of width w: the state an XNOR LFSR can never leave.
   function automatic logic [31:0] lockup_val(input int w);
      return 32'hFFFF_FFFF >> (MAX_W - w);
   endfunction

endpackage

// File: rtl/lfsr_stats_if.sv
// lfsr_stats_if: control and statistics bus of lfsr_stats.
interface lfsr_stats_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             clear_stats;
   logic             lfsr_out;
   logic [WIDTH-1:0] lfsr_state;
   logic             max_tick;
   logic [CNT_W-1:0] num_ones;
   logic [CNT_W-1:0] num_zeroes;
   logic [CNT_W-1:0] period_len;
   logic             load_err;

   modport master (
      output en, load, load_value, clear_stats,
      input  lfsr_out, lfsr_state, max_tick, num_ones, num_zeroes, period_len, load_err
   );

   modport slave (
      input  en, load, load_value, clear_stats,
      output lfsr_out, lfsr_state, max_tick, num_ones, num_zeroes, period_len, load_err
   );
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: XNOR Fibonacci LFSR state register with load, active seed and
// lockup guard. Load has priority over stepping.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
   parameter logic [WIDTH-1:0] SEED  = 16'hB4F3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic [WIDTH-1:0] o_state,
   output logic [WIDTH-1:0] o_next,
   output logic [WIDTH-1:0] o_seed,
   output logic             o_load_acc,
   output logic             o_load_rej
);
   localparam logic [31:0]      LOCKUP32 = lockup_val(WIDTH);
   localparam logic [WIDTH-1:0] LOCKUP   = LOCKUP32[WIDTH-1:0];

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_seed;
   logic             w_fb;
   logic [WIDTH-1:0] w_next;

   assign w_fb       = ~^(r_state & TAPS);
   assign w_next     = {r_state[WIDTH-2:0], w_fb};
   assign o_load_acc = i_load & (i_load_value != LOCKUP);
   assign o_load_rej = i_load & (i_load_value == LOCKUP);

   // State/seed update: accepted load, else step (never into lockup); a rejected load just holds.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SEED;
         r_seed  <= SEED;
      end else if (o_load_acc) begin
         r_state <= i_load_value;
         r_seed  <= i_load_value;
      end else if (i_en && !i_load && (w_next != LOCKUP)) begin
         r_state <= w_next;
      end
   end

   assign o_state = r_state;
   assign o_next  = w_next;
   assign o_seed  = r_seed;
endmodule

// File: rtl/lfsr_stats.sv
// lfsr_stats: LFSR plus per-period statistics (ones, zeroes, length) that are
// snapshotted and flagged with max_tick whenever the sequence returns to its seed.
module lfsr_stats
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
   parameter logic [WIDTH-1:0] SEED  = 16'hB4F3,
   parameter int               CNT_W = 16
) (
   input logic         clk,
   input logic         reset_n,
   lfsr_stats_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] w_state, w_next, w_seed;
   logic             w_load_acc, w_load_rej, w_step, w_wrap, w_msb;
   logic [CNT_W-1:0] r_ones, r_zeroes, r_steps;
   logic [CNT_W-1:0] w_ones_n, w_zeroes_n, w_steps_n;
   logic [CNT_W-1:0] r_num_ones, r_num_zeroes, r_period_len;
   logic             r_max_tick, r_load_err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
      .i_clk        (clk),
      .i_rst_n      (reset_n),
      .i_en         (bus.en),
      .i_load       (bus.load),
      .i_load_value (bus.load_value),
      .o_state      (w_state),
      .o_next       (w_next),
      .o_seed       (w_seed),
      .o_load_acc   (w_load_acc),
      .o_load_rej   (w_load_rej)
   );

   // A load cycle (accepted or not) never steps or counts.
   assign w_step     = bus.en & ~bus.load;
   assign w_msb      = w_state[WIDTH-1];
   assign w_wrap     = w_step & (w_next == w_seed);
   assign w_ones_n   = w_msb ? sat_inc(r_ones) : r_ones;
   assign w_zeroes_n = w_msb ? r_zeroes : sat_inc(r_zeroes);
   assign w_steps_n  = sat_inc(r_steps);

   // Running counters, period snapshot on wrap, max_tick pulse and sticky load error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ones       <= '0;
         r_zeroes     <= '0;
         r_steps      <= '0;
         r_num_ones   <= '0;
         r_num_zeroes <= '0;
         r_period_len <= '0;
         r_max_tick   <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_max_tick <= w_wrap;
         r_load_err <= r_load_err | w_load_rej;
         if (w_load_acc) begin
            r_ones   <= '0;
            r_zeroes <= '0;
            r_steps  <= '0;
         end else if (w_step) begin
            if (w_wrap) begin
               r_num_ones   <= w_ones_n;
               r_num_zeroes <= w_zeroes_n;
               r_period_len <= w_steps_n;
            end
            if (w_wrap || bus.clear_stats) begin
               r_ones   <= '0;
               r_zeroes <= '0;
               r_steps  <= '0;
            end else begin
               r_ones   <= w_ones_n;
               r_zeroes <= w_zeroes_n;
               r_steps  <= w_steps_n;
            end
         end else if (bus.clear_stats) begin
            r_ones   <= '0;
            r_zeroes <= '0;
            r_steps  <= '0;
         end
      end
   end

   assign bus.lfsr_out   = w_msb;
   assign bus.lfsr_state = w_state;
   assign bus.max_tick   = r_max_tick;
   assign bus.num_ones   = r_num_ones;
   assign bus.num_zeroes = r_num_zeroes;
   assign bus.period_len = r_period_len;
   assign bus.load_err   = r_load_err;
endmodule

// File: tb/tb_lfsr_stats.sv
// tb_lfsr_stats: directed checks on a default 16-bit instance, a CNT_W=8 copy
// sharing its stimulus, and a 4-bit instance.
module tb_lfsr_stats;
   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   n0, n8, n4, last0, last4;

   lfsr_stats_if #(.WIDTH(16), .CNT_W(16)) bus0 ();
   lfsr_stats_if #(.WIDTH(16), .CNT_W(8))  bus8 ();
   lfsr_stats_if #(.WIDTH(4),  .CNT_W(16)) bus4 ();

   assign bus8.en          = bus0.en;
   assign bus8.load        = bus0.load;
   assign bus8.load_value  = bus0.load_value;
   assign bus8.clear_stats = bus0.clear_stats;

   lfsr_stats u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
   lfsr_stats #(.CNT_W(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
   lfsr_stats #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .CNT_W(16)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .bus(bus4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      bus0.en = 1'b0; bus0.load = 1'b0; bus0.load_value = '0; bus0.clear_stats = 1'b0;
      bus4.en = 1'b0; bus4.load = 1'b0; bus4.load_value = '0; bus4.clear_stats = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_state0", bus0.lfsr_state, 16'hB4F3);
      chk("rst_out0",   bus0.lfsr_out, 1'b1);
      chk("rst_tick0",  bus0.max_tick, 1'b0);
      chk("rst_len0",   bus0.period_len, 16'h0);
      chk("rst_ones0",  bus0.num_ones, 16'h0);
      chk("rst_err0",   bus0.load_err, 1'b0);
      chk("rst_state4", bus4.lfsr_state, 4'h1);
      reset_n = 1'b1;

      // idle hold with en low
      @(negedge clk);
      chk("hold_state0", bus0.lfsr_state, 16'hB4F3);
      chk("hold_tick0",  bus0.max_tick, 1'b0);

      // 4-bit: three steps, then a clear_stats step, then the rest of the period
      bus4.en = 1'b1;
      @(negedge clk); chk("w4_s1", bus4.lfsr_state, 4'h3);
      @(negedge clk); chk("w4_s2", bus4.lfsr_state, 4'h7);
      @(negedge clk); chk("w4_s3", bus4.lfsr_state, 4'hE);
      bus4.clear_stats = 1'b1;
      @(negedge clk); chk("w4_clr_state", bus4.lfsr_state, 4'hD);
      bus4.clear_stats = 1'b0;
      repeat (10) @(negedge clk);
      chk("w4_pre_tick", bus4.max_tick, 1'b0);
      @(negedge clk);
      chk("w4_clr_tick",  bus4.max_tick, 1'b1);
      chk("w4_clr_state", bus4.lfsr_state, 4'h1);
      chk("w4_clr_len",   bus4.period_len, 16'd11);
      chk("w4_clr_ones",  bus4.num_ones, 16'd6);
      chk("w4_clr_zero",  bus4.num_zeroes, 16'd5);

      // 4-bit: one full period
      n4 = 0; last4 = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (bus4.max_tick) begin n4++; last4 = i; end
      end
      chk("w4_full_ticks", n4, 1);
      chk("w4_full_when",  last4, 15);
      chk("w4_full_len",   bus4.period_len, 16'd15);
      chk("w4_full_ones",  bus4.num_ones, 16'd7);
      chk("w4_full_zero",  bus4.num_zeroes, 16'd8);

      // 4-bit: load 5 mid-period with en high, next tick 15 steps later
      repeat (4) @(negedge clk);
      chk("w4_pre_load", bus4.lfsr_state, 4'hD);
      bus4.load = 1'b1; bus4.load_value = 4'h5;
      @(negedge clk);
      bus4.load = 1'b0;
      chk("w4_load_state", bus4.lfsr_state, 4'h5);
      chk("w4_load_tick",  bus4.max_tick, 1'b0);
      n4 = 0; last4 = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (bus4.max_tick) begin n4++; last4 = i; end
      end
      chk("w4_ld_ticks", n4, 1);
      chk("w4_ld_when",  last4, 15);
      chk("w4_ld_state", bus4.lfsr_state, 4'h5);
      chk("w4_ld_len",   bus4.period_len, 16'd15);
      bus4.en = 1'b0;

      // 16-bit: all-ones load rejected, error sticky
      bus0.load = 1'b1; bus0.load_value = 16'hFFFF;
      @(negedge clk);
      bus0.load = 1'b0;
      chk("rej_state", bus0.lfsr_state, 16'hB4F3);
      chk("rej_err",   bus0.load_err, 1'b1);
      repeat (3) @(negedge clk);
      chk("rej_err_sticky", bus0.load_err, 1'b1);

      // 16-bit: load 0001 with en high (load wins), then steps
      bus0.load = 1'b1; bus0.load_value = 16'h0001; bus0.en = 1'b1;
      @(negedge clk);
      bus0.load = 1'b0;
      chk("ld1_state", bus0.lfsr_state, 16'h0001);
      chk("ld1_tick",  bus0.max_tick, 1'b0);
      chk("ld1_err",   bus0.load_err, 1'b1);
      @(negedge clk); chk("ld1_s1", bus0.lfsr_state, 16'h0003);
      @(negedge clk); chk("ld1_s2", bus0.lfsr_state, 16'h0007);
      @(negedge clk); chk("ld1_s3", bus0.lfsr_state, 16'h000F);
      @(negedge clk); chk("ld1_s4", bus0.lfsr_state, 16'h001E);
      repeat (296) @(negedge clk);

      // mid-period reset, en stays high
      reset_n = 1'b0;
      #1;
      chk("mrst_state", bus0.lfsr_state, 16'hB4F3);
      chk("mrst_err",   bus0.load_err, 1'b0);
      chk("mrst_tick",  bus0.max_tick, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // full 16-bit period from reset
      n0 = 0; n8 = 0; last0 = 0;
      for (int i = 1; i <= 65535; i++) begin
         @(negedge clk);
         if (i == 1) chk("p_s1", bus0.lfsr_state, 16'h69E7);
         if (i == 2) chk("p_s2", bus0.lfsr_state, 16'hD3CE);
         if (i == 3) chk("p_s3", bus0.lfsr_state, 16'hA79D);
         if (bus0.max_tick) begin n0++; last0 = i; end
         if (bus8.max_tick) n8++;
      end
      bus0.en = 1'b0;
      chk("p_ticks",  n0, 1);
      chk("p_when",   last0, 65535);
      chk("p_state",  bus0.lfsr_state, 16'hB4F3);
      chk("p_len",    bus0.period_len, 16'd65535);
      chk("p_ones",   bus0.num_ones, 16'd32767);
      chk("p_zero",   bus0.num_zeroes, 16'd32768);
      chk("sat_ticks", n8, 1);
      chk("sat_len",  bus8.period_len, 8'd255);
      chk("sat_ones", bus8.num_ones, 8'd255);
      chk("sat_zero", bus8.num_zeroes, 8'd255);
      @(negedge clk);
      chk("post_tick",  bus0.max_tick, 1'b0);
      chk("post_state", bus0.lfsr_state, 16'hB4F3);
      chk("post_len",   bus0.period_len, 16'd65535);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
